e_mdu: RTL

- Multi-cycle multiply/divide unit for the E stage of the pipelined MIPS core.
- Sits beside the combinational ALU and is the sequential counterpart to it: it owns the HI/LO registers, executes mult/multu/div/divu over a fixed number of cycles, and serves mfhi/mflo/mthi/mtlo.
- The hazard unit stalls D whenever an MDU instruction meets `Start` or `Busy`.

---
 rtl/e_mdu_pkg.sv | 25 ++
 rtl/e_mdu.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/e_mdu_pkg.sv
// rtl/e_mdu_pkg.sv - shared op codes and defaults for the E-stage multiply/divide unit
//
// Holds the MDUOp encoding (MDU_NONE .. MDU_MADDU), the operation code width
// and the default busy lengths for multiply and divide.
package e_mdu_pkg;

  localparam int MDU_OP_W            = 4;
  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10
  } mdu_op_e;

endpackage

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - multi-cycle multiply/divide unit owning the HI/LO registers
//
// The result is computed with plain operators at the start edge and parked in
// temporaries; a down-counter then models the fixed latency and HI/LO are
// updated on the edge where the counter reaches zero.
//
// Optional feature: define MDU_MADD_EN to enable madd/maddu (codes 9/10);
// without it those codes behave as none.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-low reset
//   MDUOp   in   [3:0] operation code (see e_mdu_pkg)
//   Start   in   qualifies mult/multu/div/divu/madd/maddu this cycle
//   A, B    in   [31:0] forwarded rs/rt operands
//   Busy    out  operation in flight
//   HI, LO  out  [31:0] HI/LO registers
//   MDUOut  out  [31:0] combinational mfhi/mflo read data, 0 otherwise
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [MDU_OP_W-1:0] MDUOp,
  input  logic                Start,
  input  logic [31:0]         A,
  input  logic [31:0]         B,
  output logic                Busy,
  output logic [31:0]         HI,
  output logic [31:0]         LO,
  output logic [31:0]         MDUOut
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
  logic             tmp_wr_q, tmp_wr_d;
  state_e           state;

  logic             start_op;
  logic             op_div;
  logic [63:0]      res;
  logic             res_wr;

  logic signed [63:0] a_sx, b_sx;
  logic [63:0]        prod_s, prod_u;
  logic signed [31:0] quo_s, rem_s;
  logic [31:0]        quo_u, rem_u;

  // The counter value is the state: non-zero means an operation is in flight.
  assign state = (cnt_q != '0) ? ST_RUN : ST_IDLE;
  assign Busy  = (state == ST_RUN);
  assign HI    = hi_q;
  assign LO    = lo_q;

  // Operands are sign/zero extended to 64 bits so the product keeps all bits.
  assign a_sx   = {{32{A[31]}}, A};
  assign b_sx   = {{32{B[31]}}, B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed / and % truncate toward zero, so the remainder follows the dividend.
  // With B=0 these values are never written back.
  assign quo_s = $signed(A) / $signed(B);
  assign rem_s = $signed(A) % $signed(B);
  assign quo_u = A / B;
  assign rem_u = A % B;

  always_comb begin
    start_op = 1'b0;
    op_div   = 1'b0;
    res      = 64'd0;
    res_wr   = 1'b1;
    case (MDUOp)
      MDU_MULT: begin
        start_op = 1'b1;
        res      = prod_s;
      end
      MDU_MULTU: begin
        start_op = 1'b1;
        res      = prod_u;
      end
      MDU_DIV: begin
        start_op = 1'b1;
        op_div   = 1'b1;
        res      = {rem_s, quo_s};
        res_wr   = (B != 32'd0);
      end
      MDU_DIVU: begin
        start_op = 1'b1;
        op_div   = 1'b1;
        res      = {rem_u, quo_u};
        res_wr   = (B != 32'd0);
      end
`ifdef MDU_MADD_EN
      // Accumulate base is HI/LO as they stand at the start edge.
      MDU_MADD: begin
        start_op = 1'b1;
        res      = {hi_q, lo_q} + prod_s;
      end
      MDU_MADDU: begin
        start_op = 1'b1;
        res      = {hi_q, lo_q} + prod_u;
      end
`endif
      default: begin
        res_wr = 1'b0;
      end
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    tmp_wr_d = tmp_wr_q;
    case (state)
      ST_IDLE: begin
        if (Start && start_op) begin
          cnt_d    = op_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          tmp_hi_d = res[63:32];
          tmp_lo_d = res[31:0];
          tmp_wr_d = res_wr;
        end else if (MDUOp == MDU_MTHI) begin
          hi_d = A;
        end else if (MDUOp == MDU_MTLO) begin
          lo_d = A;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1) && tmp_wr_q) begin
          hi_d = tmp_hi_q;
          lo_d = tmp_lo_q;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
      tmp_wr_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      tmp_wr_q <= tmp_wr_d;
    end
  end

  always_comb begin
    MDUOut = 32'd0;
    if (MDUOp == MDU_MFHI) begin
      MDUOut = hi_q;
    end else if (MDUOp == MDU_MFLO) begin
      MDUOut = lo_q;
    end
  end

endmodule
